// File: rtl/fifo_pack_drain.sv
// Drain stage for a show-ahead FIFO: packs RATIO narrow entries into one wide word
// and presents it on a registered valid/ready port; partial words leave on flush or idle timeout.
module fifo_pack_drain #(
   parameter int unsigned IN_WIDTH = 8,
   parameter int unsigned RATIO    = 4,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic                          fifo_empty,
   input  logic [IN_WIDTH-1:0]           fifo_rdata,
   output logic                          fifo_ren,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [IN_WIDTH*RATIO-1:0]     out_data,
   output logic [RATIO-1:0]              out_keep,
   output logic [$clog2(RATIO+1)-1:0]    pack_cnt
);

   localparam int unsigned CW = $clog2(RATIO + 1);
   localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);
   localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);
   localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FILL,
      ST_FULL
   } state_e;

   state_e                          state_q, state_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic                            flush_pend_q, flush_pend_d;
   logic [TW-1:0]                   idle_q, idle_d;
   logic [RATIO-1:0][IN_WIDTH-1:0]  pack_q, pack_d;
   logic [RATIO-1:0][IN_WIDTH-1:0]  word_q, word_d;
   logic [RATIO-1:0]                keep_q, keep_d;
   logic                            valid_q, valid_d;

   logic out_free;
   logic tmo_fire;
   logic drain_req;
   logic pop;

   always_comb begin
      out_free  = !valid_q || out_ready;
      tmo_fire  = (TIMEOUT != 0) && (idle_q == IDLE_MAX) && (cnt_q != '0);
      drain_req = flush_pend_q || tmo_fire;
      pop       = rst_n && !clear && !fifo_empty && (state_q != ST_FULL) && !drain_req;
   end

   assign fifo_ren = pop;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q;
      idle_d       = idle_q;
      pack_d       = pack_q;
      word_d       = word_q;
      keep_d       = keep_q;
      valid_d      = valid_q && !out_ready;

      if (clear) begin
         cnt_d        = '0;
         flush_pend_d = 1'b0;
         idle_d       = '0;
         pack_d       = '0;
         word_d       = '0;
         keep_d       = '0;
         valid_d      = 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY, ST_FILL: begin
               if (pop) begin
                  for (int unsigned i = 0; i < RATIO; i++) begin
                     if (cnt_q == CW'(i)) pack_d[i] = fifo_rdata;
                  end
                  // Completing lane goes straight to the output when it is free.
                  if ((cnt_q == CNT_LAST) && out_free) begin
                     word_d  = pack_d;
                     keep_d  = '1;
                     valid_d = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else if (drain_req && out_free) begin
                  for (int unsigned i = 0; i < RATIO; i++) begin
                     if (CW'(i) < cnt_q) begin
                        word_d[i] = pack_q[i];
                        keep_d[i] = 1'b1;
                     end else begin
                        word_d[i] = '0;
                        keep_d[i] = 1'b0;
                     end
                  end
                  valid_d = 1'b1;
                  cnt_d   = '0;
               end
            end
            ST_FULL: begin
               if (out_free) begin
                  word_d  = pack_q;
                  keep_d  = '1;
                  valid_d = 1'b1;
                  cnt_d   = '0;
               end
            end
            default: cnt_d = '0;
         endcase

         // A pending flush dies with the word it was waiting for.
         flush_pend_d = (flush_pend_q || (flush && (cnt_q != '0))) && (cnt_d != '0);

         if (pop || (state_q != ST_FILL)) begin
            idle_d = '0;
         end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + TW'(1);
         end
      end

      if (cnt_d == '0) begin
         state_d = ST_EMPTY;
      end else if (cnt_d == CNT_FULL) begin
         state_d = ST_FULL;
      end else begin
         state_d = ST_FILL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         idle_q       <= '0;
         pack_q       <= '0;
         word_q       <= '0;
         keep_q       <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         idle_q       <= idle_d;
         pack_q       <= pack_d;
         word_q       <= word_d;
         keep_q       <= keep_d;
         valid_q      <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = word_q;
   assign out_keep  = keep_q;
   assign pack_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_pack_drain.sv
// Directed and random bench for fifo_pack_drain; output words are checked against
// a chunking model of the popped entry stream.
module tb_fifo_pack_drain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, clear, fifo_empty, flush, out_ready, fifo_ren, out_valid;
   logic [7:0]  fifo_rdata;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic [2:0]  pack_cnt;

   logic        clear_z, fifo_empty_z, flush_z, out_ready_z, fifo_ren_z, out_valid_z;
   logic [7:0]  fifo_rdata_z;
   logic [31:0] out_data_z;
   logic [3:0]  out_keep_z;
   logic [2:0]  pack_cnt_z;

   fifo_pack_drain #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_keep(out_keep), .pack_cnt(pack_cnt)
   );

   fifo_pack_drain #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .clear(clear_z), .fifo_empty(fifo_empty_z),
      .fifo_rdata(fifo_rdata_z), .fifo_ren(fifo_ren_z), .flush(flush_z),
      .out_valid(out_valid_z), .out_ready(out_ready_z), .out_data(out_data_z),
      .out_keep(out_keep_z), .pack_cnt(pack_cnt_z)
   );

   int          total = 0;
   int          bad = 0;
   logic [7:0]  fifo_q[$];
   logic [35:0] exp_q[$];
   logic [7:0]  s[$];
   logic [7:0]  junk;

   logic        s_ren, s_valid, s_ready;
   logic [31:0] s_data;
   logic [3:0]  s_keep;
   logic [2:0]  s_cnt;
   logic        h_armed;
   logic [31:0] h_data;
   logic [3:0]  h_keep;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      fifo_empty = (fifo_q.size() == 0);
      fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      refresh();
   endtask

   // Reference: the entry stream cut into RATIO-lane words, last one partial.
   task automatic expect_chunks(input logic [7:0] q[$]);
      for (int i = 0; i < q.size(); i += 4) begin
         logic [31:0] d;
         logic [3:0]  k;
         d = '0;
         k = '0;
         for (int j = 0; j < 4 && (i + j) < q.size(); j++) begin
            d[j*8 +: 8] = q[i+j];
            k[j] = 1'b1;
         end
         exp_q.push_back({k, d});
      end
   endtask

   // Entered at posedge+1; samples at posedge-1, returns at the next posedge+1.
   task automatic cyc();
      logic [35:0] e;
      #8;
      s_ren   = fifo_ren;
      s_valid = out_valid;
      s_ready = out_ready;
      s_data  = out_data;
      s_keep  = out_keep;
      s_cnt   = pack_cnt;
      check("cnt_range", 64'(s_cnt <= 3'd4), 64'(1));
      if (s_cnt == 3'd4) check("no_pop_full", 64'(s_ren), 64'(0));
      if (h_armed) begin
         check("hold_valid", 64'(s_valid), 64'(1));
         check("hold_data", 64'(s_data), 64'(h_data));
         check("hold_keep", 64'(s_keep), 64'(h_keep));
      end
      if (s_valid && s_ready && rst_n && !clear) begin
         if (exp_q.size() == 0) begin
            check("sb_extra_word", 64'(exp_q.size()), 64'(1));
         end else begin
            e = exp_q.pop_front();
            check("sb_data", 64'(s_data), 64'(e[31:0]));
            check("sb_keep", 64'(s_keep), 64'(e[35:32]));
         end
      end
      h_armed = s_valid && !s_ready && rst_n && !clear;
      h_data  = s_data;
      h_keep  = s_keep;
      @(posedge clk);
      #1;
      if (s_ren && fifo_q.size() != 0) begin
         junk = fifo_q.pop_front();
         refresh();
      end
   endtask

   initial begin
      int cnt_acc;
      int lat;
      rst_n = 1'b0; clear = 1'b0; flush = 1'b0; out_ready = 1'b1;
      clear_z = 1'b0; fifo_empty_z = 1'b1; fifo_rdata_z = 8'h00; flush_z = 1'b0; out_ready_z = 1'b1;
      h_armed = 1'b0;
      refresh();
      for (int b = 1; b <= 8; b++) push(8'(b));
      @(posedge clk); #1;
      cyc(); cyc();
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_data", 64'(out_data), 64'(0));
      check("rst_keep", 64'(out_keep), 64'(0));
      check("rst_cnt", 64'(pack_cnt), 64'(0));
      check("rst_ren", 64'(fifo_ren), 64'(0));

      // streaming
      s = fifo_q;
      expect_chunks(s);
      rst_n = 1'b1;
      cnt_acc = 0;
      for (int c = 1; c <= 10; c++) begin
         cyc();
         if (c <= 8) cnt_acc += int'(s_ren);
         if (c == 5) begin
            check("st_w1_valid", 64'(s_valid), 64'(1));
            check("st_w1_data", 64'(s_data), 64'(32'h04030201));
            check("st_w1_keep", 64'(s_keep), 64'(4'hF));
         end
         if (c == 9) begin
            check("st_w2_valid", 64'(s_valid), 64'(1));
            check("st_w2_data", 64'(s_data), 64'(32'h08070605));
            check("st_ren_stop", 64'(s_ren), 64'(0));
         end
      end
      check("st_ren_cycles", 64'(cnt_acc), 64'(8));

      // backpressure
      out_ready = 1'b0;
      s.delete();
      for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
      foreach (s[i]) push(s[i]);
      expect_chunks(s);
      cnt_acc = 0;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         cnt_acc += int'(s_ren);
      end
      check("bp_pops", 64'(cnt_acc), 64'(8));
      check("bp_cnt_full", 64'(pack_cnt), 64'(4));
      check("bp_ren_off", 64'(fifo_ren), 64'(0));
      check("bp_w1_data", 64'(out_data), 64'({s[3], s[2], s[1], s[0]}));
      out_ready = 1'b1;
      for (int c = 1; c <= 20; c++) cyc();
      check("bp_drained", 64'(exp_q.size()), 64'(0));

      // flush
      s.delete();
      s.push_back(8'hAA); s.push_back(8'hBB); s.push_back(8'hCC);
      foreach (s[i]) push(s[i]);
      expect_chunks(s);
      for (int c = 1; c <= 4; c++) cyc();
      check("fl_cnt3", 64'(pack_cnt), 64'(3));
      flush = 1'b1; cyc(); flush = 1'b0; cyc(); cyc();
      check("fl_valid", 64'(s_valid), 64'(1));
      check("fl_data", 64'(s_data), 64'(32'h00CCBBAA));
      check("fl_keep", 64'(s_keep), 64'(4'b0111));
      check("fl_cnt0", 64'(s_cnt), 64'(0));
      flush = 1'b1; cyc(); flush = 1'b0;
      cnt_acc = 0;
      for (int c = 1; c <= 4; c++) begin
         cyc();
         cnt_acc += int'(s_valid);
      end
      check("fl_empty_none", 64'(cnt_acc), 64'(0));

      // timeout
      push(8'h5A);
      exp_q.push_back({4'b0001, 32'h0000005A});
      cyc();
      check("tmo_pop", 64'(s_ren), 64'(1));
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         cyc();
         if (s_valid) begin
            lat = i - 1;
            break;
         end
      end
      check("tmo_latency", 64'(lat), 64'(17));
      check("tmo_data", 64'(s_data), 64'(32'h0000005A));
      check("tmo_keep", 64'(s_keep), 64'(4'b0001));

      // clear with cnt=2 and a stalled output word
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(8'($urandom));
      for (int c = 1; c <= 8; c++) cyc();
      check("clr_pre_cnt", 64'(pack_cnt), 64'(2));
      check("clr_pre_valid", 64'(out_valid), 64'(1));
      s.delete();
      for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
      foreach (s[i]) push(s[i]);
      clear = 1'b1; flush = 1'b1;
      cyc();
      check("clr_ren", 64'(s_ren), 64'(0));
      clear = 1'b0; flush = 1'b0; out_ready = 1'b1;
      expect_chunks(s);
      cyc();
      check("clr_valid", 64'(s_valid), 64'(0));
      check("clr_cnt", 64'(s_cnt), 64'(0));
      check("clr_data", 64'(s_data), 64'(0));
      check("clr_keep", 64'(s_keep), 64'(0));
      for (int c = 1; c <= 8; c++) cyc();
      check("clr_repack", 64'(exp_q.size()), 64'(0));

      // asynchronous reset mid-word
      push(8'($urandom)); push(8'($urandom));
      cyc(); cyc();
      check("rr_pre_cnt", 64'(pack_cnt), 64'(2));
      for (int i = 0; i < 4; i++) push(8'($urandom));
      rst_n = 1'b0;
      h_armed = 1'b0;
      #1;
      check("rr_valid", 64'(out_valid), 64'(0));
      check("rr_data", 64'(out_data), 64'(0));
      check("rr_keep", 64'(out_keep), 64'(0));
      check("rr_cnt", 64'(pack_cnt), 64'(0));
      check("rr_ren", 64'(fifo_ren), 64'(0));
      exp_q.delete();
      #8;
      @(posedge clk); #1;
      cyc();
      s = fifo_q;
      expect_chunks(s);
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) cyc();
      check("rr_repack", 64'(exp_q.size()), 64'(0));

      // random stream with random backpressure
      s.delete();
      lat = 4 * int'($urandom_range(6, 12)) + int'($urandom_range(1, 3));
      for (int i = 0; i < lat; i++) s.push_back(8'($urandom));
      foreach (s[i]) push(s[i]);
      expect_chunks(s);
      for (int c = 0; c < 2000 && (exp_q.size() != 0 || fifo_q.size() != 0); c++) begin
         out_ready = 1'($urandom_range(0, 1));
         cyc();
      end
      check("rnd_drained", 64'(exp_q.size()), 64'(0));
      out_ready = 1'b1;
      for (int c = 1; c <= 4; c++) cyc();

      // TIMEOUT=0 instance never auto-flushes
      fifo_empty_z = 1'b0; fifo_rdata_z = 8'h3C;
      #1;
      check("t0_ren", 64'(fifo_ren_z), 64'(1));
      cyc();
      fifo_empty_z = 1'b1;
      cnt_acc = 0;
      for (int c = 1; c <= 40; c++) begin
         cyc();
         cnt_acc += int'(out_valid_z);
      end
      check("t0_nofire", 64'(cnt_acc), 64'(0));
      check("t0_cnt", 64'(pack_cnt_z), 64'(1));
      flush_z = 1'b1; cyc(); flush_z = 1'b0; cyc();
      check("t0_fl_valid", 64'(out_valid_z), 64'(1));
      check("t0_fl_data", 64'(out_data_z), 64'(32'h0000003C));
      check("t0_fl_keep", 64'(out_keep_z), 64'(4'b0001));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
